// File: rtl/color_sensor_pkg.sv
// Shared types for the color sensor front end: filter channel, reported color and FSM state.
package color_sensor_pkg;

  typedef enum logic [1:0] {
    CH_RED   = 2'b00,
    CH_BLUE  = 2'b01,
    CH_CLEAR = 2'b10,
    CH_GREEN = 2'b11
  } ch_e;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'd0,
    COLOR_RED   = 2'd1,
    COLOR_GREEN = 2'd2,
    COLOR_BLUE  = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_GATE   = 2'd1,
    ST_STORE  = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous sensor output into the clk domain and flags each rising edge.
// rise is a one-cycle pulse, 2-3 clk edges after the sensor edge.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sensor;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/color_sensor_freq.sv
// Cycles the sensor filter through red/blue/clear/green, counts output edges per gate window
// and reports the latched counts plus the dominant color once per frame.
module color_sensor_freq
  import color_sensor_pkg::*;
#(
  parameter int         GATE_CYCLES   = 40,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         CNT_W         = 16,
  parameter logic [1:0] FREQ_SCALE    = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] clear,
  output logic [CNT_W-1:0] green,
  output logic [1:0]       ch,
  output logic             valid,
  output logic             frame_done,
  output logic [1:0]       color_id
);

  localparam int TMR_W = $clog2(GATE_CYCLES + SETTLE_CYCLES + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           r_state;
  ch_e              r_ch;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_blue;
  logic [CNT_W-1:0] r_clear;
  logic [CNT_W-1:0] r_green;
  logic             r_valid;
  logic             r_frame_done;
  color_e           r_color;
  color_e           w_color;
  logic             w_rise;

  edge_sync u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor),
    .rise   (w_rise)
  );

  // Green is still in r_cnt during STORE, so classify against it rather than r_green.
  always_comb begin
    w_color = COLOR_NONE;
    if (r_red == '0 && r_blue == '0 && r_cnt == '0)
      w_color = COLOR_NONE;
    else if (r_red >= r_cnt && r_red >= r_blue)
      w_color = COLOR_RED;
    else if (r_cnt >= r_blue)
      w_color = COLOR_GREEN;
    else
      w_color = COLOR_BLUE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_SETTLE;
      r_ch         <= CH_RED;
      r_tmr        <= '0;
      r_cnt        <= '0;
      r_red        <= '0;
      r_blue       <= '0;
      r_clear      <= '0;
      r_green      <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_color      <= COLOR_NONE;
    end else begin
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          r_cnt <= '0;
          if (r_tmr == SETTLE_LAST) begin
            r_tmr   <= '0;
            r_state <= ST_GATE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_GATE: begin
          if (w_rise && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
          if (r_tmr == GATE_LAST) begin
            r_tmr   <= '0;
            r_state <= ST_STORE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_STORE: begin
          case (r_ch)
            CH_RED:   r_red   <= r_cnt;
            CH_BLUE:  r_blue  <= r_cnt;
            CH_CLEAR: r_clear <= r_cnt;
            CH_GREEN: r_green <= r_cnt;
            default:  r_red   <= r_cnt;
          endcase
          r_valid <= 1'b1;
          if (r_ch == CH_GREEN) begin
            r_frame_done <= 1'b1;
            r_color      <= w_color;
          end
          r_ch    <= ch_e'(r_ch + 2'd1);
          r_cnt   <= '0;
          r_state <= ST_SETTLE;
        end
        default: begin
          r_tmr   <= '0;
          r_cnt   <= '0;
          r_state <= ST_SETTLE;
        end
      endcase
    end
  end

  assign s0         = FREQ_SCALE[0];
  assign s1         = FREQ_SCALE[1];
  assign s2         = r_ch[1];
  assign s3         = r_ch[0];
  assign ch         = r_ch;
  assign red        = r_red;
  assign blue       = r_blue;
  assign clear      = r_clear;
  assign green      = r_green;
  assign valid      = r_valid;
  assign frame_done = r_frame_done;
  assign color_id   = r_color;

endmodule

// File: tb/tb_color_sensor_freq.sv
// Bench for color_sensor_freq: default instance plus a CNT_W=3 instance sharing one sensor line,
// compared against a model that counts synchronized rising edges from the recorded sensor history.
module tb_color_sensor_freq;

  localparam int CH_T  = 49;
  localparam int FRAME = 196;
  localparam int HMAX  = 2048;

  logic        clk;
  logic        reset;
  logic        sensor;
  logic        s0, s1, s2, s3;
  logic [15:0] red, blue, clear, green;
  logic [1:0]  ch, color_id;
  logic        valid, frame_done;
  logic        t_s0, t_s1, t_s2, t_s3;
  logic [2:0]  t_red, t_blue, t_clear, t_green;
  logic [1:0]  t_ch, t_color_id;
  logic        t_valid, t_frame_done;

  color_sensor_freq u_dut (
    .clk(clk), .reset(reset), .sensor(sensor),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3),
    .red(red), .blue(blue), .clear(clear), .green(green),
    .ch(ch), .valid(valid), .frame_done(frame_done), .color_id(color_id)
  );

  color_sensor_freq #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .sensor(sensor),
    .s0(t_s0), .s1(t_s1), .s2(t_s2), .s3(t_s3),
    .red(t_red), .blue(t_blue), .clear(t_clear), .green(t_green),
    .ch(t_ch), .valid(t_valid), .frame_done(t_frame_done), .color_id(t_color_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hist [HMAX];
  int exp_m [4];
  int exp_s [4];
  int exp_cid_m = 0;
  int exp_cid_s = 0;

  // Stimulus controls: per-channel half period (0 = constant level), or random noise.
  int hp [4];
  bit lvl [4];
  bit noise = 1'b0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Sensor waveform keyed on the filter lines; phase restarts whenever the filter changes.
  initial begin
    logic [1:0] key;
    logic [1:0] last_key;
    int phase;
    sensor   = 1'b0;
    last_key = 2'b00;
    phase    = 0;
    forever begin
      @(negedge clk);
      key = {s2, s3};
      if (noise) begin
        sensor = 1'($urandom % 2);
      end else begin
        if (key != last_key) begin
          phase    = 0;
          last_key = key;
        end
        if (hp[key] == 0) begin
          sensor = lvl[key];
        end else begin
          phase++;
          if (phase >= hp[key]) begin
            phase  = 0;
            sensor = ~sensor;
          end
        end
      end
    end
  end

  // A rise counted on edge e comes from sensor samples taken on edges e-2 (high) and e-3 (low).
  function automatic int count_ch(input int n, input int maxv);
    int s = 0;
    for (int e = CH_T*n + 9; e <= CH_T*n + 48; e++)
      if (hist[e-2] == 1 && hist[e-3] == 0) s++;
    return (s > maxv) ? maxv : s;
  endfunction

  function automatic int dominant(input int r, input int g, input int b);
    if (r == 0 && g == 0 && b == 0) return 0;
    if (r >= g && r >= b) return 1;
    if (g >= b) return 2;
    return 3;
  endfunction

  task automatic check_results(input string pfx);
    check({pfx, "_red"},   int'(red),   exp_m[0]);
    check({pfx, "_blue"},  int'(blue),  exp_m[1]);
    check({pfx, "_clear"}, int'(clear), exp_m[2]);
    check({pfx, "_green"}, int'(green), exp_m[3]);
    check({pfx, "_cid"},   int'(color_id), exp_cid_m);
    check({pfx, "_sat_red"},   int'(t_red),   exp_s[0]);
    check({pfx, "_sat_blue"},  int'(t_blue),  exp_s[1]);
    check({pfx, "_sat_clear"}, int'(t_clear), exp_s[2]);
    check({pfx, "_sat_green"}, int'(t_green), exp_s[3]);
    check({pfx, "_sat_cid"},   int'(t_color_id), exp_cid_s);
  endtask

  task automatic step();
    int n, c, exp_ch;
    @(posedge clk);
    cyc++;
    hist[cyc] = int'(sensor);
    if (cyc % CH_T == 0) begin
      n = cyc / CH_T - 1;
      c = n % 4;
      exp_m[c] = count_ch(n, 65535);
      exp_s[c] = count_ch(n, 7);
      if (c == 3) begin
        exp_cid_m = dominant(exp_m[0], exp_m[3], exp_m[1]);
        exp_cid_s = dominant(exp_s[0], exp_s[3], exp_s[1]);
      end
    end
    #1;
    exp_ch = (cyc / CH_T) % 4;
    check("valid",      int'(valid),      int'(cyc % CH_T == 0));
    check("frame_done", int'(frame_done), int'(cyc % FRAME == 0));
    check("ch",         int'(ch),         exp_ch);
    check("s2",         int'(s2),         exp_ch / 2);
    check("s3",         int'(s3),         exp_ch % 2);
    check("sat_valid",  int'(t_valid),    int'(cyc % CH_T == 0));
    if (cyc % CH_T == 0) check_results("wr");
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < HMAX; i++) hist[i] = 0;
    for (int k = 0; k < 4; k++) begin
      exp_m[k] = 0;
      exp_s[k] = 0;
    end
    exp_cid_m = 0;
    exp_cid_s = 0;
    check("rst_s0", int'(s0), 1);
    check("rst_s1", int'(s1), 1);
    check("rst_s2", int'(s2), 0);
    check("rst_s3", int'(s3), 0);
    check("rst_ch", int'(ch), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check_results("rst");
  endtask

  task automatic set_hp(input int r, input int b, input int c, input int g);
    noise = 1'b0;
    hp[0] = r; hp[1] = b; hp[2] = c; hp[3] = g;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hp[k]  = 0;
      lvl[k] = 1'b0;
    end

    // Period 4 on every channel: 10 edges per window, 7 on the 3-bit instance.
    set_hp(2, 2, 2, 2);
    do_reset(2);
    repeat (FRAME) step();
    check("p4_red", int'(red), 10);
    check("p4_blue", int'(blue), 10);
    check("p4_clear", int'(clear), 10);
    check("p4_green", int'(green), 10);
    check("p4_cid", int'(color_id), 1);
    check("sat_red", int'(t_red), 7);
    check("sat_green", int'(t_green), 7);

    // Constant low, then constant high.
    for (int lv = 0; lv < 2; lv++) begin
      set_hp(0, 0, 0, 0);
      for (int k = 0; k < 4; k++) lvl[k] = 1'(lv);
      do_reset(2);
      repeat (FRAME) step();
      check("const_red", int'(red), 0);
      check("const_blue", int'(blue), 0);
      check("const_clear", int'(clear), 0);
      check("const_green", int'(green), 0);
      check("const_cid", int'(color_id), 0);
    end

    // Frequency keyed on the filter: periods 4/20/4/8.
    set_hp(2, 10, 2, 4);
    do_reset(2);
    repeat (FRAME) step();
    check("key_red", int'(red), 10);
    check("key_blue", int'(blue), 2);
    check("key_clear", int'(clear), 10);
    check("key_green", int'(green), 5);
    check("key_cid", int'(color_id), 1);

    // Red/green tie resolves to red.
    set_hp(4, 10, 2, 4);
    do_reset(2);
    repeat (FRAME) step();
    check("tie_red", int'(red), 5);
    check("tie_green", int'(green), 5);
    check("tie_cid", int'(color_id), 1);

    // Reset for one cycle in the middle of the blue gate window.
    set_hp(2, 2, 2, 2);
    do_reset(2);
    repeat (77) step();
    check("pre_rst_red", int'(red), 10);
    do_reset(1);
    repeat (CH_T) step();
    check("post_rst_valid", int'(valid), 1);
    check("post_rst_red", int'(red), 10);
    check("post_rst_blue", int'(blue), 0);
    repeat (FRAME - CH_T) step();

    // Randomized waveforms and noise over two frames each.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) begin
        hp[k]  = $urandom_range(0, 12);
        lvl[k] = 1'($urandom % 2);
      end
      noise = (t % 3 == 2);
      do_reset(2);
      repeat (2 * FRAME) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
